// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Display time base and anode driver for a two-digit 7-segment display.
// Scans units, blank, tens, blank; the decoder input is latched once per frame.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int LZ_BLANK    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       en,
  output logic [3:0] s,
  output logic       bot,
  output logic       an0,
  output logic       an1
);

  localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW      = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            LZ_ON    = (LZ_BLANK != 0);

  typedef enum logic [1:0] {
    UNITS   = 2'd0,
    BLANK_A = 2'd1,
    TENS    = 2'd2,
    BLANK_B = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            slot_last_s;
  logic            latch_s;

  logic [3:0]      sync1_r;
  logic [3:0]      sync2_r;
  logic [3:0]      s_r;
  logic [3:0]      s_next_s;
  logic            bot_r;
  logic            bot_next_s;
  logic            an0_r;
  logic            an0_next_s;
  logic            an1_r;
  logic            an1_next_s;
  logic            tens_hidden_s;

  // Two-flop synchronizer for the asynchronous switch input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
    end else begin
      sync1_r <= sw;
      sync2_r <= sync1_r;
    end
  end

  // Slot end detection, next state and counter update
  always_comb begin
    slot_last_s  = 1'b0;
    state_next_s = state_r;
    cnt_next_s   = cnt_r + CNT_ONE;
    case (state_r)
      UNITS:   slot_last_s = (cnt_r == REF_LAST);
      BLANK_A: slot_last_s = (cnt_r == BLK_LAST);
      TENS:    slot_last_s = (cnt_r == REF_LAST);
      BLANK_B: slot_last_s = (cnt_r == BLK_LAST);
      default: slot_last_s = 1'b1;
    endcase
    if (slot_last_s) begin
      cnt_next_s = CNT_ZERO;
      case (state_r)
        UNITS:   state_next_s = BLANK_A;
        BLANK_A: state_next_s = TENS;
        TENS:    state_next_s = BLANK_B;
        BLANK_B: state_next_s = UNITS;
        default: state_next_s = BLANK_B;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM state and slot counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BLANK_B;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Output decode from the next state, so outputs change on the same edge as the state
  always_comb begin
    latch_s       = 1'b0;
    s_next_s      = s_r;
    bot_next_s    = 1'b1;
    an0_next_s    = 1'b1;
    an1_next_s    = 1'b1;
    tens_hidden_s = LZ_ON && (s_r < 4'd10);
    if (slot_last_s && (state_r == BLANK_B)) begin
      latch_s  = 1'b1;
      s_next_s = sync2_r;
    end else begin
      latch_s  = 1'b0;
      s_next_s = s_r;
    end
    // s only changes on entry to UNITS, so s_r is already stable for the tens decision
    case (state_next_s)
      UNITS: begin
        bot_next_s = 1'b1;
        an0_next_s = ~en;
        an1_next_s = 1'b1;
      end
      BLANK_A: begin
        bot_next_s = 1'b0;
        an0_next_s = 1'b1;
        an1_next_s = 1'b1;
      end
      TENS: begin
        bot_next_s = 1'b0;
        an0_next_s = 1'b1;
        an1_next_s = ~(en && !tens_hidden_s);
      end
      BLANK_B: begin
        bot_next_s = 1'b1;
        an0_next_s = 1'b1;
        an1_next_s = 1'b1;
      end
      default: begin
        bot_next_s = 1'b1;
        an0_next_s = 1'b1;
        an1_next_s = 1'b1;
      end
    endcase
  end

  // Registered outputs: frame latch, digit select and anode enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r   <= 4'd0;
      bot_r <= 1'b1;
      an0_r <= 1'b1;
      an1_r <= 1'b1;
    end else begin
      s_r   <= s_next_s;
      bot_r <= bot_next_s;
      an0_r <= an0_next_s;
      an1_r <= an1_next_s;
    end
  end

  assign s   = s_r;
  assign bot = bot_r;
  assign an0 = an0_r;
  assign an1 = an1_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for seg_scan_ctrl: stimulus pushes expected per-cycle outputs,
// a monitor pops and compares them each cycle (and on demand for async reset).
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       en = 1'b1;
  logic [3:0] s, s_b;
  logic       bot, bot_b, an0, an0_b, an1, an1_b;

  int errors = 0;
  int checks = 0;
  int rec_idx = 0;

  // {an0, an1, an1 of LZ_BLANK=0 instance, bot, s}
  logic [7:0] exp_q[$];
  event       sample_ev;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .en(en),
    .s(s), .bot(bot), .an0(an0), .an1(an1)
  );

  seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2), .LZ_BLANK(0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .sw(sw), .en(en),
    .s(s_b), .bot(bot_b), .an0(an0_b), .an1(an1_b)
  );

  // Monitor: compare DUT outputs against the head of the expectation queue
  initial begin
    logic [7:0] e;
    logic [7:0] act;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {an0, an1, an1_b, bot, s};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL out[%0d] t=%0t got an0/an1/an1nolz/bot/s=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                   rec_idx, $time, act[7], act[6], act[5], act[4], act[3:0],
                   e[7], e[6], e[5], e[4], e[3:0]);
        end
        rec_idx++;
      end
    end
  end

  task automatic push(input logic a0, input logic a1, input logic a1b,
                      input logic b, input logic [3:0] sv);
    exp_q.push_back({a0, a1, a1b, b, sv});
  endtask

  // One 20-cycle frame with latched value sv, en held high
  task automatic push_frame(input logic [3:0] sv);
    logic tens_on;
    tens_on = (sv >= 4'd10);
    for (int i = 0; i < 8; i++) push(1'b0, 1'b1, 1'b1, 1'b1, sv);
    for (int i = 0; i < 2; i++) push(1'b1, 1'b1, 1'b1, 1'b0, sv);
    for (int i = 0; i < 8; i++) push(1'b1, ~tens_on, 1'b0, 1'b0, sv);
    for (int i = 0; i < 2; i++) push(1'b1, 1'b1, 1'b1, 1'b1, sv);
  endtask

  // Wait (bounded) until every expectation has been consumed; returns on a posedge
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Assert reset between edges and check the outputs before the next clock edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    ->sample_ev;
    @(negedge clk);
    #2;
  endtask

  // After release: one more blank cycle in BLANK_B (the one before edge 1 is
  // unsampled), then frames. The sync flops restart at 0 and need 2 edges, which
  // equals BLANK_CYC, so the first frame after reset always latches 0.
  initial begin
    // Phase 1: plain reset release with sw=0
    repeat (2) @(posedge clk);
    sw = 4'd0;
    async_reset();
    push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    push_frame(4'd0);
    rst_n = 1'b1;

    // Phase 2: sw=13, reset lands mid-UNITS (an0 low) and must clear at once
    drain();
    sw = 4'd13;
    async_reset();
    push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    push_frame(4'd0);
    push_frame(4'd13);
    push_frame(4'd13);
    rst_n = 1'b1;

    // Phase 3: sw=5, tens suppressed on the LZ_BLANK=1 instance only
    drain();
    sw = 4'd5;
    async_reset();
    push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    push_frame(4'd0);
    push_frame(4'd5);
    push_frame(4'd5);
    rst_n = 1'b1;

    // Phase 4: sw 13 -> 7 during TENS of the 13 frame
    drain();
    sw = 4'd13;
    async_reset();
    push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    push_frame(4'd0);
    push_frame(4'd13);
    push_frame(4'd7);
    rst_n = 1'b1;
    repeat (34) @(negedge clk);
    sw = 4'd7;

    // Phase 5: reset pulse in the middle of TENS (an1 low) of a 13 frame
    drain();
    sw = 4'd13;
    async_reset();
    push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    push_frame(4'd0);
    for (int i = 0; i < 8; i++) push(1'b0, 1'b1, 1'b1, 1'b1, 4'd13);
    for (int i = 0; i < 2; i++) push(1'b1, 1'b1, 1'b1, 1'b0, 4'd13);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 4'd13);
    rst_n = 1'b1;
    drain();
    async_reset();
    push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    push_frame(4'd0);
    push_frame(4'd13);
    rst_n = 1'b1;

    // Phase 6: en low for 5 cycles inside UNITS; slot timing unchanged
    drain();
    sw = 4'd13;
    async_reset();
    push(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    push_frame(4'd0);
    for (int i = 3; i <= 7; i++) exp_q[i][7] = 1'b1;
    push_frame(4'd13);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;

    drain();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
